// File: rtl/comp_acc_pkg.sv
// Shared types and default widths for the compensation accumulation path.
package comp_acc_pkg;

  localparam int unsigned CMP_IN_WIDTH   = 13;
  localparam int unsigned CMP_ACC_WIDTH  = 17;
  localparam int unsigned CMP_DEPTH      = 8;
  localparam int unsigned CMP_PASS_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_e;

endpackage

// File: rtl/comp_sat_add.sv
// Combinational sign-extend, add and clamp of a compensation sum into an entry.
module comp_sat_add
  import comp_acc_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = CMP_IN_WIDTH,
  parameter int unsigned ACC_WIDTH = CMP_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [IN_WIDTH-1:0]  data,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 overflow
);

  // One guard bit above the accumulator is enough to detect any overflow.
  localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] acc_s;
  logic signed [IN_WIDTH-1:0]  data_s;
  logic signed [SUM_WIDTH-1:0] acc_ext;
  logic signed [SUM_WIDTH-1:0] data_ext;
  logic signed [SUM_WIDTH-1:0] raw;

  // Widen both operands, add, and clamp when the guard bit disagrees with the sign.
  always_comb begin
    acc_s    = acc;
    data_s   = data;
    acc_ext  = SUM_WIDTH'(acc_s);
    data_ext = SUM_WIDTH'(data_s);
    raw      = acc_ext + data_ext;
    overflow = raw[SUM_WIDTH-1] ^ raw[SUM_WIDTH-2];
    sum      = raw[ACC_WIDTH-1:0];
    if (overflow) begin
      sum = raw[SUM_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/comp_acc_bank.sv
// Per-column compensation partial-sum bank: multi-pass saturating accumulate,
// then in-order drain over a valid/ready stream.
module comp_acc_bank
  import comp_acc_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = CMP_IN_WIDTH,
  parameter int unsigned ACC_WIDTH  = CMP_ACC_WIDTH,
  parameter int unsigned DEPTH      = CMP_DEPTH,
  parameter int unsigned PASS_WIDTH = CMP_PASS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [PASS_WIDTH-1:0] cfg_passes,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  sat_flag
);

  localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(DEPTH - 1);

  acc_state_e state;
  acc_state_e state_next;

  logic [IDX_WIDTH-1:0]  idx;
  logic [PASS_WIDTH-1:0] pass;
  logic [PASS_WIDTH-1:0] passes_q;
  logic                  sat_q;
  logic [ACC_WIDTH-1:0]  entry [DEPTH];

  logic                  start_ok;
  logic                  in_fire;
  logic                  out_fire;
  logic                  idx_wrap;
  logic                  last_pass;
  logic                  accum_done;
  logic                  drain_done;
  logic [ACC_WIDTH-1:0]  add_base;
  logic [ACC_WIDTH-1:0]  add_sum;
  logic                  add_ovf;

  // Handshake and sequencing qualifiers shared by the FSM and datapath.
  always_comb begin
    start_ok   = cfg_start && (state == IDLE);
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    idx_wrap   = (idx == IDX_LAST);
    last_pass  = (pass == (passes_q - PASS_WIDTH'(1)));
    accum_done = in_fire && idx_wrap && last_pass;
    drain_done = out_fire && idx_wrap;
    // First pass overwrites stale contents instead of adding to them.
    add_base   = (pass == '0) ? '0 : entry[idx];
  end

  comp_sat_add #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat_add (
    .acc      (add_base),
    .data     (in_data),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_start)  state_next = ACCUM;
      ACCUM:   if (accum_done) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; drain data comes straight from the entry selected by idx.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_data  = entry[idx];
    sat_flag  = sat_q;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = idx_wrap;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Column index, pass counter, pass target and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      pass     <= '0;
      passes_q <= PASS_WIDTH'(1);
      sat_q    <= 1'b0;
    end else if (start_ok) begin
      idx      <= '0;
      pass     <= '0;
      passes_q <= (cfg_passes == '0) ? PASS_WIDTH'(1) : cfg_passes;
      sat_q    <= 1'b0;
    end else if (in_fire) begin
      if (add_ovf) begin
        sat_q <= 1'b1;
      end
      if (idx_wrap) begin
        idx  <= '0;
        pass <= pass + PASS_WIDTH'(1);
      end else begin
        idx <= idx + IDX_WIDTH'(1);
      end
    end else if (out_fire) begin
      idx <= idx_wrap ? '0 : idx + IDX_WIDTH'(1);
    end
  end

  // Entry storage: cleared by reset, written at idx on each accepted input beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else if (in_fire) begin
      entry[idx] <= add_sum;
    end
  end

endmodule
